// File: rtl/encoder_scheduler.sv
// Round-robin scheduler feeding 7-bit words from two requesters into the half-rate encoder,
// metering one word per two cycles and flushing the encoder pipeline after every grant.
module encoder_scheduler #(
  parameter int BURST_MAX   = 8,
  parameter int FLUSH_WORDS = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [6:0] a_data,
  input  logic       a_half,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_data,
  input  logic       b_half,
  input  logic       b_last,
  output logic       b_ready,
  output logic [6:0] enc_in,
  output logic       enc_half,
  output logic       enc_trig,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PRIME, LOAD, HOLD, DRAIN, GAP} state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  localparam logic [2:0] FLUSH_END = 3'(2 * FLUSH_WORDS - 1);
  localparam logic [2:0] GAP_END   = 3'(GAP_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] burst_cnt;
  logic [1:0] bubble_cnt;
  logic [2:0] flush_cnt;
  logic [2:0] gap_cnt;
  logic       last_reg;
  logic       served_b;
  logic [1:0] pick;
  logic       sel_valid, sel_half, sel_last;
  logic [6:0] sel_data;

  // A wins unless it was served last and B is also waiting
  always_comb begin
    pick = 2'b00;
    if (a_valid && (served_b || !b_valid)) pick = 2'b01;
    else if (b_valid)                      pick = 2'b10;
  end

  always_comb begin
    sel_valid = grant[1] ? b_valid : a_valid;
    sel_data  = grant[1] ? b_data  : a_data;
    sel_half  = grant[1] ? b_half  : a_half;
    sel_last  = grant[1] ? b_last  : a_last;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (a_valid || b_valid) state_nx = PRIME;
      PRIME:   state_nx = LOAD;
      LOAD:    state_nx = HOLD;
      HOLD: begin
        if (last_reg || (burst_cnt == BURST_LIM) || (bubble_cnt == 2'd2)) state_nx = DRAIN;
        else                                                              state_nx = LOAD;
      end
      DRAIN:   if (flush_cnt == FLUSH_END) state_nx = GAP;
      GAP:     if (gap_cnt == GAP_END) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset gates ready so an abandoned grant never completes a handshake
  assign a_ready = rst_n && (state == LOAD) && grant[0];
  assign b_ready = rst_n && (state == LOAD) && grant[1];
  assign busy    = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= IDLE;
      enc_in     <= 7'd0;
      enc_half   <= 1'b1;
      enc_trig   <= 1'b1;
      grant      <= 2'b00;
      burst_cnt  <= 4'd0;
      bubble_cnt <= 2'd0;
      flush_cnt  <= 3'd0;
      gap_cnt    <= 3'd0;
      last_reg   <= 1'b0;
      served_b   <= 1'b1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (state_nx == PRIME) begin
            grant      <= pick;
            enc_trig   <= 1'b0;
            burst_cnt  <= 4'd0;
            bubble_cnt <= 2'd0;
            last_reg   <= 1'b0;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            enc_in     <= sel_data;
            enc_half   <= sel_half;
            last_reg   <= sel_last;
            bubble_cnt <= 2'd0;
            if (burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + 4'd1;
          end else begin
            enc_in     <= 7'd0;
            enc_half   <= 1'b1;
            last_reg   <= 1'b0;
            bubble_cnt <= bubble_cnt + 2'd1;
          end
        end
        HOLD: begin
          if (state_nx == DRAIN) flush_cnt <= 3'd0;
        end
        DRAIN: begin
          flush_cnt <= flush_cnt + 3'd1;
          // Even cycles are the load-like phases where a fresh fill word is clocked in
          if (!flush_cnt[0]) begin
            enc_in   <= 7'd0;
            enc_half <= 1'b1;
          end
          if (state_nx == GAP) begin
            enc_trig <= 1'b1;
            served_b <= grant[1];
            grant    <= 2'b00;
            gap_cnt  <= 3'd0;
            enc_in   <= 7'd0;
            enc_half <= 1'b1;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_scheduler.sv
// Scoreboard bench for encoder_scheduler: words accepted at LOAD are queued and
// checked against the encoder input in the following HOLD cycle.
module tb_encoder_scheduler;

  typedef struct packed {
    logic       v;
    logic       last;
    logic       half;
    logic [6:0] data;
  } word_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, a_half = 1'b0, a_last = 1'b0, a_ready;
  logic [6:0] a_data = 7'd0;
  logic       b_valid = 1'b0, b_half = 1'b0, b_last = 1'b0, b_ready;
  logic [6:0] b_data = 7'd0;
  logic [6:0] enc_in;
  logic       enc_half, enc_trig, busy;
  logic [1:0] grant;

  logic       rst2_n = 1'b0;
  logic       a2_ready, b2_ready, enc2_half, enc2_trig, busy2;
  logic [6:0] enc2_in;
  logic [1:0] grant2;

  word_t      a_q[$], b_q[$];
  logic [7:0] sb_q[$];
  logic [1:0] rec_owner[$], rec2_owner[$];
  int         rec_words[$], rec2_words[$];
  int         rdy_cyc[$];
  logic       a_pres = 1'b0, b_pres = 1'b0, pend = 1'b0;
  logic [1:0] prev_grant = 2'b00, prev_grant2 = 2'b00;
  logic       prev_busy = 1'b0;
  int         total = 0, bad = 0, cyc = 0;
  int         cur_words = 0, cur_words2 = 0;
  int         trig_low = 0, gap_seen = 0, first_valid = -1, busy_fall = -1;

  always #5 clock = ~clock;

  encoder_scheduler #(.BURST_MAX(8), .FLUSH_WORDS(2), .GAP_CYCLES(2)) dut (
    .clock(clock), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_half(a_half), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_half(b_half), .b_last(b_last), .b_ready(b_ready),
    .enc_in(enc_in), .enc_half(enc_half), .enc_trig(enc_trig), .grant(grant), .busy(busy)
  );

  encoder_scheduler #(.BURST_MAX(1), .FLUSH_WORDS(2), .GAP_CYCLES(2)) dut_b1 (
    .clock(clock), .rst_n(rst2_n),
    .a_valid(1'b1), .a_data(7'h2A), .a_half(1'b0), .a_last(1'b0), .a_ready(a2_ready),
    .b_valid(1'b1), .b_data(7'h55), .b_half(1'b1), .b_last(1'b0), .b_ready(b2_ready),
    .enc_in(enc2_in), .enc_half(enc2_half), .enc_trig(enc2_trig), .grant(grant2), .busy(busy2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic side, input logic v, input logic last,
                               input logic half, input logic [6:0] data);
    word_t w;
    w = '{v: v, last: last, half: half, data: data};
    if (side) b_q.push_back(w);
    else      a_q.push_back(w);
  endtask

  task automatic clearStats();
    rec_owner.delete();
    rec_words.delete();
    rdy_cyc.delete();
    trig_low = 0; gap_seen = 0; first_valid = -1; busy_fall = -1;
  endtask

  task automatic applyReset();
    @(posedge clock); #1;
    rst_n = 1'b0;
    a_q.delete();
    b_q.delete();
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    clearStats();
  endtask

  task automatic waitGrants(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rec_owner.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    if (rec_owner.size() < n) checkOutput(tag, rec_owner.size(), n);
  endtask

  task automatic checkGrant(input string tag, input int idx, input logic [1:0] owner, input int words);
    if (idx < rec_owner.size()) begin
      checkOutput({tag, "_owner"}, rec_owner[idx], owner);
      checkOutput({tag, "_words"}, rec_words[idx], words);
    end else begin
      checkOutput({tag, "_missing"}, rec_owner.size(), idx + 1);
    end
  endtask

  // Requester drivers: present the queue head just after each edge
  initial forever begin
    @(posedge clock); #2;
    a_pres = (a_q.size() > 0);
    if (a_pres) begin
      a_valid = a_q[0].v; a_data = a_q[0].data; a_half = a_q[0].half; a_last = a_q[0].last;
    end else begin
      a_valid = 1'b0; a_last = 1'b0;
    end
    b_pres = (b_q.size() > 0);
    if (b_pres) begin
      b_valid = b_q[0].v; b_data = b_q[0].data; b_half = b_q[0].half; b_last = b_q[0].last;
    end else begin
      b_valid = 1'b0; b_last = 1'b0;
    end
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (pend && sb_q.size() > 0) checkOutput("enc_word", {enc_half, enc_in}, sb_q.pop_front());
    pend = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      cur_words = 0;
      prev_grant = 2'b00;
      prev_busy = 1'b0;
    end else begin
      if (a_ready || b_ready) begin
        checkOutput("ready_owner", {a_ready, b_ready}, {grant[0], grant[1]});
        if (a_ready) begin
          if (a_valid) begin sb_q.push_back({a_half, a_data}); cur_words++; end
          else         sb_q.push_back(8'h80);
          if (a_pres) begin void'(a_q.pop_front()); a_pres = 1'b0; end
          rdy_cyc.push_back(cyc);
        end
        if (b_ready) begin
          if (b_valid) begin sb_q.push_back({b_half, b_data}); cur_words++; end
          else         sb_q.push_back(8'h80);
          if (b_pres) begin void'(b_q.pop_front()); b_pres = 1'b0; end
        end
        pend = 1'b1;
      end
      if (prev_grant != 2'b00 && grant == 2'b00) begin
        rec_owner.push_back(prev_grant);
        rec_words.push_back(cur_words);
        cur_words = 0;
      end
      if (!enc_trig) trig_low++;
      if (busy && grant == 2'b00) gap_seen++;
      if (a_valid && first_valid < 0) first_valid = cyc;
      if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
      prev_grant = grant;
      prev_busy = busy;
    end
  end

  // Grant log of the single-word-burst instance, both requesters always valid
  initial forever begin
    @(negedge clock);
    if (rst2_n) begin
      if (a2_ready || b2_ready) cur_words2++;
      if (prev_grant2 != 2'b00 && grant2 == 2'b00 && rec2_owner.size() < 4) begin
        rec2_owner.push_back(prev_grant2);
        rec2_words.push_back(cur_words2);
      end
      if (prev_grant2 != 2'b00 && grant2 == 2'b00) cur_words2 = 0;
      prev_grant2 = grant2;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 rst2_n = 1'b1;
  end

  initial begin
    // Reset state
    applyReset();
    @(negedge clock);
    checkOutput("rst_trig", enc_trig, 1'b1);
    checkOutput("rst_word", {enc_half, enc_in}, 8'h80);
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", {a_ready, b_ready}, 2'b00);

    // Single A packet of three words
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h41);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7'h22);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'h13);
    waitGrants(1, 60, "t1_timeout");
    repeat (5) @(posedge clock);
    checkGrant("t1", 0, 2'b01, 3);
    checkOutput("t1_nready", rdy_cyc.size(), 3);
    for (int i = 0; i < 3 && i < rdy_cyc.size(); i++)
      checkOutput("t1_ready_lat", rdy_cyc[i] - first_valid, 2 * (i + 1));
    checkOutput("t1_trig_low", trig_low, 11);
    checkOutput("t1_gap_grant0", gap_seen, 2);
    checkOutput("t1_busy_fall", busy_fall - first_valid, 14);

    // Continuous A and B, no last: bounded bursts alternate
    applyReset();
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, i[0], 7'(i + 8'h10));
      applyStimulus(1'b1, 1'b1, 1'b0, i[1], 7'(i + 8'h40));
    end
    waitGrants(3, 200, "t2_timeout");
    checkGrant("t2_g0", 0, 2'b01, 8);
    checkGrant("t2_g1", 1, 2'b10, 8);
    checkGrant("t2_g2", 2, 2'b01, 8);
    checkOutput("t2_gap_grant0", gap_seen >= 4, 1'b1);

    // One bubble keeps the grant
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h55);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 7'h2A);
    waitGrants(1, 60, "t3_timeout");
    checkGrant("t3", 0, 2'b01, 2);

    // Two bubbles end the grant, then B is served
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7'h66);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7'h77);
    waitGrants(2, 100, "t4_timeout");
    checkGrant("t4_g0", 0, 2'b01, 1);
    checkGrant("t4_g1", 1, 2'b10, 2);

    // Reset pulse during HOLD of the second word
    applyReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'(i));
    begin
      int k;
      k = 0;
      while (cur_words < 2 && k < 40) begin
        @(posedge clock);
        k++;
      end
      if (cur_words < 2) checkOutput("t5_timeout", cur_words, 2);
    end
    #1 rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 7'h70);
    @(posedge clock);
    #1 rst_n = 1'b1;
    clearStats();
    @(negedge clock);
    checkOutput("t5_trig", enc_trig, 1'b1);
    checkOutput("t5_word", {enc_half, enc_in}, 8'h80);
    checkOutput("t5_grant", grant, 2'b00);
    checkOutput("t5_busy", busy, 1'b0);
    waitGrants(1, 60, "t5_grant_timeout");
    checkGrant("t5", 0, 2'b01, 2);

    // Single-word bursts alternate A and B
    for (int i = 0; i < 4; i++) begin
      if (i < rec2_owner.size()) begin
        checkOutput("b1_owner", rec2_owner[i], i[0] ? 2'b10 : 2'b01);
        checkOutput("b1_words", rec2_words[i], 1);
      end else begin
        checkOutput("b1_missing", rec2_owner.size(), 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_scheduler.md
# encoder_scheduler

- Sequences 7-bit symbol words from two independent requesters (A, B) into the 7-bit half-rate encoder.
- Encoder side:
  - Drives the encoder's `in`, `half` and `trig` inputs.
  - Keeps the encoder's divided clock in a known phase.
  - Meters one word per two `clock` cycles.
  - Flushes the encoder pipeline at the end of every grant.
- Arbitration: round-robin between A and B, with bounded bursts.
- Placement: sits between the packetising front end and the encoder.

## Interface
Parameters:
- `BURST_MAX`, 8: max words accepted per grant (1..15).
- `FLUSH_WORDS`, 2: fill words driven after a grant ends, to drain the encoder pipeline (1..3).
- `GAP_CYCLES`, 2: cycles `enc_trig` is held high between grants (1..7).

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `a_valid` in 1: requester A has a word.
- `a_data` in 7: A word.
- `a_half` in 1: A half flag for the word.
- `a_last` in 1: word is last of A's packet.
- `a_ready` out 1: A word accepted this cycle when `a_valid & a_ready`.
- `b_valid`, `b_data`[7], `b_half`, `b_last` in; `b_ready` out: same for B.
- `enc_in` out 7: encoder data input.
- `enc_half` out 1: encoder half input.
- `enc_trig` out 1: encoder trig; high holds the encoder's divided clock low.
- `grant` out 2: one-hot owner (01=A, 10=B, 00=none).
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset (`rst_n`=0 at an edge), from the next cycle:
  - State IDLE.
  - `enc_in`=0, `enc_half`=1, `enc_trig`=1.
  - `grant`=00, `busy`=0, `a_ready`=`b_ready`=0.
  - Burst count=0, bubble count=0, flush count=0.
  - Last-served = B, so A wins the first tie.
  - Reset mid-burst abandons the grant immediately: no flush, no handshake completes in the reset cycle.
- States: IDLE, PRIME, LOAD, HOLD, DRAIN, GAP.
- IDLE:
  - `enc_trig`=1.
  - If any valid: grant the requester not last served if it is valid, else the other. Go to PRIME.
- PRIME (1 cycle):
  - `enc_trig`=0, no ready.
  - Encoder divided clock rises at the end of PRIME. Go to LOAD.
- LOAD (1 cycle):
  - Granted `*_ready`=1 (Moore, from registered state).
  - If the granted valid is high: register data, half and last into `enc_in`/`enc_half`; burst count +1; bubble count cleared.
  - If low: drive the fill word `enc_in`=0, `enc_half`=1; bubble count +1.
  - Go to HOLD.
- HOLD (1 cycle):
  - No ready; `enc_in` is stable while the encoder samples it at the end of HOLD.
  - Go to DRAIN if any of: registered last=1, burst count==`BURST_MAX`, or bubble count==2.
  - Otherwise go to LOAD.
- DRAIN:
  - Alternates LOAD-like/HOLD-like phases with the fill word, no ready, for `FLUSH_WORDS` words (2×`FLUSH_WORDS` cycles).
  - Then go to GAP.
- GAP:
  - `enc_trig`=1, fill word.
  - Last-served := current grant; `grant`=00 from the first GAP cycle.
  - Lasts `GAP_CYCLES` cycles, then IDLE.
- Non-granted ready is always 0.
- `*_last` and `*_data` are ignored when the matching valid is low.
- Simultaneous valids at IDLE resolve by round-robin only; there is no preemption mid-grant.
- A requester that drops valid for one LOAD gets a bubble, not loss of grant. Two consecutive bubbles end the grant.
- Counters:
  - Burst count is 4 bits and saturates at `BURST_MAX`.
  - Burst count and bubble count clear on entering PRIME.

## Timing
- Word cadence: exactly one accept opportunity per 2 cycles while granted. Peak throughput 0.5 word/cycle.
- `enc_in` updates only at the end of LOAD (encoder divided-clock falling edge). It is held 2 cycles.
- `enc_trig` changes only on IDLE→PRIME (falls) and DRAIN→GAP (rises).
- Latency: valid in IDLE to first `*_ready` = 2 cycles (IDLE, PRIME, then ready in LOAD).
- Grant turnaround, from the HOLD of the last word to the next PRIME: 2×`FLUSH_WORDS` + `GAP_CYCLES` + 1 cycles. With defaults that is 7.
- `grant` and `busy` are registered and change on the state-transition edge.

## Test plan
- **Single A packet, 3 words, last on the third:**
  - Data 7'h41, 7'h22, 7'h13, `a_valid` held.
  - `a_ready` pulses in cycles 2, 4, 6 after valid.
  - `enc_in` shows each word for 2 cycles; `enc_trig` is low from PRIME to the end of DRAIN.
  - 4 fill-word cycles, 2 GAP cycles, then `busy`=0.
- **A and B valid together from reset, both continuous, no last:**
  - Grants go A (8 words), B (8 words), A...
  - `grant` is 00 during GAP.
  - No word is accepted from the non-granted side.
- **A drops valid for one LOAD mid-burst:**
  - `enc_in`=0 and `enc_half`=1 for that word.
  - Grant is kept; the next valid word is accepted.
- **Two consecutive missed LOADs:** grant ends, DRAIN+GAP run, and B is served if valid.
- **`rst_n` low for 1 cycle during HOLD:**
  - Next cycle shows IDLE outputs (`enc_trig`=1, `enc_in`=0, `grant`=00).
  - The in-flight word is not re-presented; the next grant goes to A.
- **`BURST_MAX`=1 build:** each grant accepts exactly 1 word; A and B alternate.
